// File: rtl/mpu_tl_checker.sv
// mpu_tl_checker: region-based permission filter between the TileLink core
// arbiter and the memory port. One transaction is in flight at a time;
// violations are answered locally and never reach memory.

package tl_pkg;
  localparam int SRC_W = 4;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic             valid;
    logic [2:0]       opcode;
    logic [31:0]      address;
    logic [SRC_W-1:0] source;
    logic [31:0]      data;
  } tl_a_channel;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } tl_d_channel;
endpackage

// state  | meaning
// IDLE   | a_ready high, waiting for a granted request
// CHECK  | region lookup on the captured request
// FWD    | request presented to memory until accepted
// WAIT_D | mem_d_ready high, waiting for the memory response
// DENY   | local denied response is on d_valid
module mpu_tl_checker
  import tl_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int NUM_REGIONS   = 4,
  parameter bit DEFAULT_ALLOW = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  tl_a_channel                    in_req,
  output logic                           a_ready,
  output logic                           d_valid,
  output tl_d_channel                    resp,
  output tl_a_channel                    mem_req,
  input  logic                           mem_a_ready,
  input  logic                           mem_d_valid,
  input  tl_d_channel                    mem_resp,
  output logic                           mem_d_ready,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic [31:0]                    cfg_base,
  input  logic [31:0]                    cfg_limit,
  input  logic [1:0]                     cfg_perm,
  input  logic [NUM_CORES-1:0]           cfg_cores,
  input  logic                           cfg_en,
  output logic [CNT_W-1:0]               deny_cnt
);

  typedef enum logic [2:0] {IDLE, CHECK, FWD, WAIT_D, DENY} state_t;

  state_t                 state_q, state_d;
  tl_a_channel            req_q;
  logic [31:0]            base_q  [NUM_REGIONS];
  logic [31:0]            limit_q [NUM_REGIONS];
  logic [1:0]             perm_q  [NUM_REGIONS];
  logic [NUM_CORES-1:0]   cores_q [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q;

  logic                   src_ok, is_get, is_put, hit, permit;
  logic [1:0]             hit_perm;
  logic [NUM_REGIONS-1:0] core_hit;

  // Region table; a write lands at the clock edge, so a lookup in the same cycle sees old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        perm_q[i]  <= '0;
        cores_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_we) begin
      base_q[cfg_idx]  <= cfg_base;
      limit_q[cfg_idx] <= cfg_limit;
      perm_q[cfg_idx]  <= cfg_perm;
      cores_q[cfg_idx] <= cfg_cores;
      en_q[cfg_idx]    <= cfg_en;
    end
  end

  // Permission lookup on the captured request; lowest matching region wins.
  always_comb begin
    src_ok   = int'(req_q.source) < NUM_CORES;
    is_get   = req_q.opcode == OP_GET;
    is_put   = (req_q.opcode == OP_PUT_FULL) || (req_q.opcode == OP_PUT_PARTIAL);
    core_hit = '0;
    hit      = 1'b0;
    hit_perm = 2'b00;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (req_q.source == SRC_W'(j)) core_hit[i] = cores_q[i][j];
      end
    end
    // Walk from the top down so the lowest index is the last to overwrite.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (en_q[i] && base_q[i] <= req_q.address && req_q.address <= limit_q[i] && core_hit[i]) begin
        hit      = 1'b1;
        hit_perm = perm_q[i];
      end
    end
    if (!src_ok)  permit = 1'b0;
    else if (hit) permit = (is_get & hit_perm[0]) | (is_put & hit_perm[1]);
    else          permit = DEFAULT_ALLOW;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; a_ready is held low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    a_ready     = 1'b0;
    mem_req     = '0;
    mem_d_ready = 1'b0;
    case (state_q)
      IDLE: begin
        a_ready = rst_n;
        if (in_req.valid) state_d = CHECK;
      end
      CHECK:  state_d = permit ? FWD : DENY;
      FWD: begin
        mem_req       = req_q;
        mem_req.valid = 1'b1;
        if (mem_a_ready) state_d = WAIT_D;
      end
      WAIT_D: begin
        mem_d_ready = 1'b1;
        if (mem_d_valid) state_d = IDLE;
      end
      DENY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              req_q <= '0;
    else if (state_q == IDLE && in_req.valid) req_q <= in_req;
  end

  // One-cycle response pulse; resp is zero whenever d_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 1'b0;
      resp    <= '0;
    end else begin
      d_valid <= 1'b0;
      resp    <= '0;
      if (state_q == WAIT_D && mem_d_valid) begin
        d_valid     <= 1'b1;
        resp        <= mem_resp;
        resp.source <= req_q.source;
      end else if (state_q == CHECK && !permit) begin
        d_valid     <= 1'b1;
        resp.opcode <= is_get ? OP_ACK_DATA : OP_ACK;
        resp.source <= req_q.source;
        resp.denied <= 1'b1;
      end
    end
  end

  // Saturating count of denied requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      deny_cnt <= '0;
    else if (state_q == CHECK && !permit && deny_cnt != '1)
      deny_cnt <= deny_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_mpu_tl_checker.sv
// Bench for mpu_tl_checker: a transaction-level model of the default
// instance is compared every cycle; a second instance (default-allow,
// 2-bit counter) is pinned with directed literal expectations.
module tb_mpu_tl_checker;
  import tl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tl_a_channel in_req;
  logic        mem_a_ready, mem_d_valid;
  tl_d_channel mem_resp;
  logic        cfg_we, cfg_en;
  logic [1:0]  cfg_idx, cfg_perm;
  logic [31:0] cfg_base, cfg_limit;
  logic [3:0]  cfg_cores;

  logic        a_ready, d_valid, mem_d_ready;
  tl_d_channel resp;
  tl_a_channel mem_req;
  logic [15:0] deny_cnt;

  logic        a_ready2, d_valid2, mem_d_ready2;
  tl_d_channel resp2;
  tl_a_channel mem_req2;
  logic [1:0]  deny_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpu_tl_checker #(.NUM_CORES(4), .NUM_REGIONS(4), .DEFAULT_ALLOW(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .a_ready(a_ready), .d_valid(d_valid),
    .resp(resp), .mem_req(mem_req), .mem_a_ready(mem_a_ready), .mem_d_valid(mem_d_valid),
    .mem_resp(mem_resp), .mem_d_ready(mem_d_ready), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_perm(cfg_perm), .cfg_cores(cfg_cores),
    .cfg_en(cfg_en), .deny_cnt(deny_cnt));

  mpu_tl_checker #(.NUM_CORES(4), .NUM_REGIONS(4), .DEFAULT_ALLOW(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .a_ready(a_ready2), .d_valid(d_valid2),
    .resp(resp2), .mem_req(mem_req2), .mem_a_ready(mem_a_ready), .mem_d_valid(mem_d_valid),
    .mem_resp(mem_resp), .mem_d_ready(mem_d_ready2), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_perm(cfg_perm), .cfg_cores(cfg_cores),
    .cfg_en(cfg_en), .deny_cnt(deny_cnt2));

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- reference model (default instance) ----------------
  logic [31:0] m_base  [4];
  logic [31:0] m_limit [4];
  logic [1:0]  m_perm  [4];
  logic [3:0]  m_cores [4];
  logic [3:0]  m_en;

  logic        exp_a_ready, exp_d_valid, exp_mem_d_ready;
  tl_d_channel exp_resp;
  tl_a_channel exp_mem_req;
  logic [15:0] exp_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_en <= '0;
    else if (cfg_we) begin
      m_base[cfg_idx]  <= cfg_base;
      m_limit[cfg_idx] <= cfg_limit;
      m_perm[cfg_idx]  <= cfg_perm;
      m_cores[cfg_idx] <= cfg_cores;
      m_en[cfg_idx]    <= cfg_en;
    end
  end

  function automatic bit model_permit(input tl_a_channel r);
    if (r.source >= 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_en[i] && m_base[i] <= r.address && r.address <= m_limit[i] && m_cores[i][r.source[1:0]]) begin
        if (r.opcode == 3'd4) return m_perm[i][0];
        if (r.opcode <= 3'd1) return m_perm[i][1];
        return 1'b0;
      end
    return 1'b0;
  endfunction

  task automatic tick(output bit ab);
    @(posedge clk or negedge rst_n);
    ab = !rst_n;
  endtask

  initial begin : model
    tl_a_channel cap;
    bit ab, hs;
    forever begin
      if (!rst_n) begin
        exp_a_ready = 0; exp_d_valid = 0; exp_resp = '0; exp_mem_req = '0;
        exp_mem_d_ready = 0; exp_cnt = '0;
        wait (rst_n);
      end
      exp_a_ready = 1; exp_mem_req = '0; exp_mem_d_ready = 0;
      hs = 0; ab = 0;
      while (!hs && !ab) begin
        tick(ab);
        if (!ab) begin
          hs = in_req.valid; cap = in_req;
          exp_d_valid = 0; exp_resp = '0;
        end
      end
      if (ab) continue;
      exp_a_ready = 0;
      tick(ab);
      if (ab) continue;
      if (!model_permit(cap)) begin
        exp_d_valid = 1;
        exp_resp.opcode = (cap.opcode == 3'd4) ? 3'd1 : 3'd0;
        exp_resp.source = cap.source;
        exp_resp.denied = 1'b1;
        exp_resp.data   = '0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        tick(ab);
        if (ab) continue;
        exp_d_valid = 0; exp_resp = '0;
      end else begin
        exp_mem_req = cap; exp_mem_req.valid = 1'b1;
        do begin tick(ab); end while (!ab && !mem_a_ready);
        if (ab) continue;
        exp_mem_req = '0; exp_mem_d_ready = 1;
        do begin tick(ab); end while (!ab && !mem_d_valid);
        if (ab) continue;
        exp_mem_d_ready = 0; exp_d_valid = 1;
        exp_resp = mem_resp; exp_resp.source = cap.source;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_ready", 128'(a_ready), 128'(exp_a_ready));
    chk("d_valid", 128'(d_valid), 128'(exp_d_valid));
    chk("resp", 128'(resp), 128'(exp_resp));
    chk("mem_req", 128'(mem_req), 128'(exp_mem_req));
    chk("mem_d_ready", 128'(mem_d_ready), 128'(exp_mem_d_ready));
    chk("deny_cnt", 128'(deny_cnt), 128'(exp_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    chk("rst_a_ready", 128'(a_ready), 128'(0));
    chk("rst_deny_cnt", 128'(deny_cnt), 128'(0));
    step();
    rst_n = 1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] b, input logic [31:0] l,
                           input logic [1:0] p, input logic [3:0] c, input logic e);
    cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_perm = p; cfg_cores = c; cfg_en = e;
    cfg_we = 1;
    step();
    cfg_we = 0;
  endtask

  // Returns one cycle after the handshake edge (the lookup cycle).
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] src,
                      input logic [31:0] dat);
    int n = 0;
    while (!(a_ready && a_ready2) && n < 100) begin step(); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL send_wait a_ready low for %0d cycles, required high", n);
    end
    in_req.valid = 1; in_req.opcode = op; in_req.address = addr;
    in_req.source = src; in_req.data = dat;
    step();
    in_req.valid = 0;
  endtask

  // Accept the request this cycle, respond the next; returns in the d_valid cycle.
  task automatic fwd_complete(input logic [31:0] dat);
    mem_a_ready = 1;
    step();
    mem_a_ready = 0;
    mem_d_valid = 1;
    mem_resp.opcode = 3'd1; mem_resp.source = 4'hA; mem_resp.denied = 0; mem_resp.data = dat;
    step();
    mem_d_valid = 0; mem_resp = '0;
  endtask

  initial begin : stim
    tl_a_channel e;
    in_req = '0; mem_a_ready = 0; mem_d_valid = 0; mem_resp = '0;
    cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_limit = 0; cfg_perm = 0; cfg_cores = 0; cfg_en = 0;
    do_reset();

    // Get inside a read-only region is forwarded
    cfg_write(0, 32'h1000, 32'h1FFF, 2'b01, 4'hF, 1);
    send(3'd4, 32'h1800, 4'd2, 32'h0);
    step();
    chk("s1_mem_valid", 128'(mem_req.valid), 128'(1));
    chk("s1_mem_addr", 128'(mem_req.address), 128'(32'h1800));
    fwd_complete(32'hCAFE_F00D);
    chk("s1_d_valid", 128'(d_valid), 128'(1));
    chk("s1_src", 128'(resp.source), 128'(2));
    chk("s1_denied", 128'(resp.denied), 128'(0));
    chk("s1_data", 128'(resp.data), 128'(32'hCAFE_F00D));
    step();
    chk("s1_pulse", 128'(d_valid), 128'(0));

    // PutFull into read-only region is denied locally
    send(3'd0, 32'h1800, 4'd1, 32'h55);
    step();
    chk("s2_no_mem", 128'(mem_req.valid), 128'(0));
    chk("s2_d_valid", 128'(d_valid), 128'(1));
    chk("s2_opcode", 128'(resp.opcode), 128'(0));
    chk("s2_denied", 128'(resp.denied), 128'(1));
    chk("s2_cnt", 128'(deny_cnt), 128'(1));
    step();
    chk("s2_pulse", 128'(d_valid), 128'(0));

    // Core mask and region priority
    cfg_write(0, 32'h0, 32'hFFFF, 2'b11, 4'h1, 1);
    cfg_write(1, 32'h0, 32'hFFFF, 2'b00, 4'hF, 1);
    send(3'd4, 32'h10, 4'd0, 32'h0);
    step();
    chk("s3_src0_fwd", 128'(mem_req.valid), 128'(1));
    fwd_complete(32'h1);
    send(3'd4, 32'h10, 4'd3, 32'h0);
    step();
    chk("s3_src3_deny", 128'(resp.denied), 128'(1));
    chk("s3_src3_op", 128'(resp.opcode), 128'(1));
    cfg_write(0, 32'h0, 32'hFFFF, 2'b11, 4'h1, 0);
    send(3'd4, 32'h10, 4'd0, 32'h0);
    step();
    chk("s3_dis_deny", 128'(resp.denied), 128'(1));
    chk("s3_dis_dv", 128'(d_valid), 128'(1));

    // Default policy and address boundaries
    do_reset();
    send(3'd4, 32'h8000_0000, 4'd0, 32'h0);
    step();
    chk("s4_def0_deny", 128'(d_valid), 128'(1));
    chk("s4_def0_nomem", 128'(mem_req.valid), 128'(0));
    chk("s4_def1_fwd", 128'(mem_req2.valid), 128'(1));
    fwd_complete(32'h77);
    chk("s4_def1_dv", 128'(d_valid2), 128'(1));
    chk("s4_def1_ok", 128'(resp2.denied), 128'(0));
    cfg_write(0, 32'hFFFF_F000, 32'hFFFF_FFFF, 2'b01, 4'hF, 1);
    send(3'd4, 32'hFFFF_FFFF, 4'd1, 32'h0);
    step();
    chk("s4_top_hit", 128'(mem_req.valid), 128'(1));
    fwd_complete(32'h2);
    cfg_write(0, 32'h2000, 32'h1000, 2'b11, 4'hF, 1);
    send(3'd4, 32'h1800, 4'd0, 32'h0);
    step();
    chk("s4_inv_deny", 128'(d_valid), 128'(1));
    chk("s4_inv_def1", 128'(mem_req2.valid), 128'(1));
    fwd_complete(32'h3);

    // Memory stall then reset while waiting for the response
    do_reset();
    cfg_write(0, 32'h0, 32'hFFFF, 2'b11, 4'hF, 1);
    send(3'd1, 32'h20, 4'd0, 32'h1234_5678);
    step();
    e.valid = 1; e.opcode = 3'd1; e.address = 32'h20; e.source = 4'd0; e.data = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      chk("s5_mem_stable", 128'(mem_req), 128'(e));
      chk("s5_a_ready", 128'(a_ready), 128'(0));
      step();
    end
    mem_a_ready = 1;
    step();
    mem_a_ready = 0;
    chk("s5_wait_d", 128'(mem_d_ready), 128'(1));
    rst_n = 0;
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      chk("s5_no_dv", 128'(d_valid), 128'(0));
      step();
    end
    chk("s5_cnt", 128'(deny_cnt), 128'(0));
    chk("s5_idle", 128'(a_ready), 128'(1));

    // Counter saturation on the 2-bit instance
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(3'd4, 32'h10, 4'd5, 32'h0);
      step();
      chk("s6_bad_src", 128'(d_valid2), 128'(1));
      step();
      if (k == 2) chk("s6_cnt2", 128'(deny_cnt2), 128'(2));
    end
    chk("s6_sat", 128'(deny_cnt2), 128'(3));
    chk("s6_cnt16", 128'(deny_cnt), 128'(5));

    // Write during the lookup cycle: old entry decides, new one applies next time
    cfg_write(0, 32'h0, 32'hFFFF, 2'b01, 4'hF, 1);
    send(3'd4, 32'h40, 4'd0, 32'h0);
    cfg_idx = 0; cfg_base = 32'h0; cfg_limit = 32'hFFFF; cfg_perm = 2'b01; cfg_cores = 4'hF;
    cfg_en = 0; cfg_we = 1;
    step();
    cfg_we = 0;
    chk("s6_old_entry", 128'(mem_req.valid), 128'(1));
    fwd_complete(32'h4);
    send(3'd4, 32'h40, 4'd0, 32'h0);
    step();
    chk("s6_new_entry", 128'(resp.denied), 128'(1));
    fwd_complete(32'h5);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_req.valid   = $urandom_range(0, 2) == 0;
      in_req.opcode  = 3'($urandom_range(0, 7));
      in_req.source  = 4'($urandom_range(0, 5));
      in_req.data    = $urandom;
      case ($urandom_range(0, 7))
        0:       in_req.address = 32'hFFFF_FFFF;
        1:       in_req.address = 32'h8000_0000;
        default: in_req.address = 32'($urandom_range(0, 32'h3FFF));
      endcase
      mem_a_ready     = $urandom_range(0, 1) == 1;
      mem_d_valid     = $urandom_range(0, 2) == 0;
      mem_resp.opcode = 3'($urandom_range(0, 7));
      mem_resp.source = 4'($urandom_range(0, 15));
      mem_resp.denied = $urandom_range(0, 3) == 0;
      mem_resp.data   = $urandom;
      cfg_we    = $urandom_range(0, 7) == 0;
      cfg_idx   = 2'($urandom_range(0, 3));
      cfg_base  = 32'($urandom_range(0, 32'h3FFF));
      case ($urandom_range(0, 5))
        0:       cfg_limit = 32'($urandom_range(0, 32'h3FFF));
        1:       cfg_limit = 32'hFFFF_FFFF;
        default: cfg_limit = cfg_base + 32'($urandom_range(0, 32'h2000));
      endcase
      cfg_perm  = 2'($urandom_range(0, 3));
      cfg_cores = 4'($urandom_range(0, 15));
      cfg_en    = $urandom_range(0, 3) != 0;
      if (c == 1500) rst_n = 0;
      if (c == 1502) rst_n = 1;
      step();
    end
    in_req.valid = 0; cfg_we = 0; mem_a_ready = 1; mem_d_valid = 1;
    repeat (10) step();
    mem_a_ready = 0; mem_d_valid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
